// File: rtl/memory_dumper_pkg.sv
// Shared constants, trit codes and FSM states for the ternary memory dumper.
// The conversion helpers are reusable by any block that decodes balanced-ternary words.
package memory_dumper_pkg;

  localparam int DUMP_TRITS   = 9;
  localparam int DUMP_WORD_W  = 2 * DUMP_TRITS;
  localparam int DUMP_COUNT_W = 10;
  localparam int DUMP_OUT_W   = 16;

  // Trit codes; 2'b11 is not a legal trit.
  localparam logic [1:0] TRIT_NEG  = 2'b10;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CONVERT,
    S_PRESENT,
    S_FINISH
  } state_t;

  function automatic logic signed [1:0] trit_value(input logic [1:0] code);
    case (code)
      TRIT_NEG: trit_value = -2'sd1;
      TRIT_POS: trit_value = 2'sd1;
      default:  trit_value = 2'sd0;
    endcase
  endfunction

  function automatic logic trit_valid(input logic [1:0] code);
    trit_valid = (code == TRIT_NEG) || (code == TRIT_ZERO) || (code == TRIT_POS);
  endfunction

endpackage

// File: rtl/memory_dumper_balanced_ternary_incrementer.sv
// Combinational balanced-ternary +1 with ripple carry; carry out of the top trit is dropped.
// Also intended for the CPU program counter.
module balanced_ternary_incrementer
  import memory_dumper_pkg::*;
#(
  parameter int TRITS = DUMP_TRITS
) (
  input  logic [2*TRITS-1:0] value,
  output logic [2*TRITS-1:0] incremented
);

  logic carry;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    incremented = value;
    carry       = 1'b1;
    for (int i = 0; i < TRITS; i++) begin
      if (carry) begin
        case (value[2*i +: 2])
          TRIT_NEG: begin incremented[2*i +: 2] = TRIT_ZERO; carry = 1'b0; end
          TRIT_POS: begin incremented[2*i +: 2] = TRIT_NEG;  carry = 1'b1; end
          default:  begin incremented[2*i +: 2] = TRIT_POS;  carry = 1'b0; end
        endcase
      end
    end
  end

endmodule

// File: rtl/memory_dumper.sv
// Reads a block of ternary words, converts each to signed binary and streams it out
// over valid/ready together with its source address.
module memory_dumper
  import memory_dumper_pkg::*;
#(
  parameter int TRITS   = DUMP_TRITS,
  parameter int COUNT_W = DUMP_COUNT_W,
  parameter int OUT_W   = DUMP_OUT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*TRITS-1:0]      start_addr,
  input  logic [COUNT_W-1:0]      word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    trit_error,
  output logic                    mem_read,
  output logic [2*TRITS-1:0]      mem_address,
  input  logic [2*TRITS-1:0]      mem_read_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [2*TRITS-1:0]      out_addr,
  output logic                    out_last
);

  localparam int IDX_W = $clog2(TRITS);

  state_t                    state;
  logic [2*TRITS-1:0]        addr;
  logic [2*TRITS-1:0]        addr_next;
  logic [2*TRITS-1:0]        word;
  logic signed [OUT_W-1:0]   acc;
  logic signed [OUT_W-1:0]   acc_next;
  logic [COUNT_W-1:0]        remaining;
  logic [IDX_W-1:0]          trit_idx;
  logic [1:0]                cur_code;
  logic signed [1:0]         cur_value;

  balanced_ternary_incrementer #(.TRITS(TRITS)) u_inc (
    .value       (addr),
    .incremented (addr_next)
  );

  // Horner step, most significant trit first: acc*3 + t.
  assign cur_code  = word[{trit_idx, 1'b0} +: 2];
  assign cur_value = trit_value(cur_code);
  assign acc_next  = (acc <<< 1) + acc + $signed({{(OUT_W-2){cur_value[1]}}, cur_value});

  assign mem_address = addr;
  assign out_addr    = addr;
  assign out_data    = acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      word       <= '0;
      acc        <= '0;
      remaining  <= '0;
      trit_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trit_error <= 1'b0;
      mem_read   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            addr       <= start_addr;
            remaining  <= word_count;
            trit_error <= 1'b0;
            busy       <= 1'b1;
            if (word_count == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state    <= S_READ;
              mem_read <= 1'b1;
            end
          end
        end
        S_READ: begin
          mem_read <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          word     <= mem_read_data;
          acc      <= '0;
          trit_idx <= IDX_W'(TRITS - 1);
          state    <= S_CONVERT;
        end
        S_CONVERT: begin
          acc      <= acc_next;
          trit_idx <= trit_idx - 1'b1;
          if (!trit_valid(cur_code)) trit_error <= 1'b1;
          if (trit_idx == '0) begin
            state     <= S_PRESENT;
            out_valid <= 1'b1;
            out_last  <= (remaining == COUNT_W'(1));
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - 1'b1;
            addr      <= addr_next;
            if (remaining == COUNT_W'(1)) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state    <= S_READ;
              mem_read <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_dumper.sv
// Self-checking bench for memory_dumper: directed corner cases plus randomized dumps
// compared against an integer-arithmetic model of balanced-ternary words and addresses.
module tb_memory_dumper;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [17:0] start_addr = '0;
  logic [9:0]  word_count = '0;
  logic        busy, done, trit_error, mem_read, out_valid, out_last;
  logic [17:0] mem_address, out_addr;
  logic [17:0] mem_read_data = '0;
  logic        out_ready = 1'b1;
  logic signed [15:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] mem [int];

  memory_dumper dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .trit_error    (trit_error),
    .mem_read      (mem_read),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_last      (out_last)
  );

  always #5 clock = ~clock;

  // Memory model: data valid the cycle after the read strobe.
  always @(posedge clock) begin
    if (mem_read) mem_read_data <= mem_word(mem_address);
  end

  function automatic logic [17:0] mem_word(input logic [17:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return '0;
  endfunction

  // Reference model: value = sum of digit * 3^i, illegal codes count as zero.
  function automatic int tern_value(input logic [17:0] w);
    int v = 0;
    int p = 1;
    for (int i = 0; i < 9; i++) begin
      if (w[2*i +: 2] == 2'b01) v += p;
      else if (w[2*i +: 2] == 2'b10) v -= p;
      p *= 3;
    end
    return v;
  endfunction

  function automatic bit tern_bad(input logic [17:0] w);
    for (int i = 0; i < 9; i++) if (w[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int wrap(input int v);
    if (v > 9841) return v - 19683;
    if (v < -9841) return v + 19683;
    return v;
  endfunction

  function automatic logic [17:0] to_tern(input int v);
    logic [17:0] w = '0;
    int r;
    for (int i = 0; i < 9; i++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 2) begin w[2*i +: 2] = 2'b10; v = (v + 1) / 3; end
      else if (r == 1) begin w[2*i +: 2] = 2'b01; v = (v - 1) / 3; end
      else begin w[2*i +: 2] = 2'b00; v = v / 3; end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [17:0] a, input logic [17:0] w,
                            input bit last, input bit err);
    logic [15:0] e = 16'(tern_value(w));
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {16'd0, out_data}, {16'd0, e});
    check({tag, "_addr"},  {14'd0, out_addr}, {14'd0, a});
    check({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
    check({tag, "_err"},   {31'd0, trit_error}, {31'd0, err});
  endtask

  task automatic run_dump(input logic [17:0] saddr, input int count, input int stall_word,
                          input int stall_cycles, input bit inject);
    int base = tern_value(saddr);
    bit err_exp = 1'b0;
    logic [17:0] a, w;
    start = 1'b1; start_addr = saddr; word_count = 10'(count);
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_err_clear", {31'd0, trit_error}, 32'd0);
    if (count == 0) begin
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_no_read", {31'd0, mem_read}, 32'd0);
      check("zero_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("zero_done_drop", {31'd0, done}, 32'd0);
      check("zero_busy_drop", {31'd0, busy}, 32'd0);
      return;
    end
    for (int k = 0; k < count; k++) begin
      a = to_tern(wrap(base + k));
      w = mem_word(a);
      check("read_strobe", {31'd0, mem_read}, 32'd1);
      check("read_addr", {14'd0, mem_address}, {14'd0, a});
      if (inject && k == 0) begin
        start = 1'b1; start_addr = to_tern(77); word_count = 10'd7;
        tick();
        start = 1'b0;
        repeat (10) tick();
      end else begin
        repeat (11) tick();
      end
      err_exp |= tern_bad(w);
      check("no_read_in_present", {31'd0, mem_read}, 32'd0);
      check_word("word", a, w, k == count - 1, err_exp);
      if (k == stall_word) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          check_word("stall", a, w, k == count - 1, err_exp);
        end
        out_ready = 1'b1;
      end
      tick();
      check("valid_drop", {31'd0, out_valid}, 32'd0);
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("done_drop", {31'd0, done}, 32'd0);
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("err_sticky", {31'd0, trit_error}, {31'd0, err_exp});
    tick();
    check("idle_no_read", {31'd0, mem_read}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [17:0] w;
    int done_seen;

    // Reset with all inputs low.
    reset = 1'b1;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, trit_error}, 32'd0);
    check("rst_read", {31'd0, mem_read}, 32'd0);
    check("rst_maddr", {14'd0, mem_address}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_oaddr", {14'd0, out_addr}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    reset = 1'b0;
    tick();

    // Single word +1 at address 0.
    mem[int'(to_tern(0))] = 18'b01;
    run_dump(to_tern(0), 1, -1, 0, 1'b0);

    // Three words: max, min, zero; consumer stalls five cycles on the second.
    mem[int'(to_tern(0))] = {9{2'b01}};
    mem[int'(to_tern(1))] = {9{2'b10}};
    mem[int'(to_tern(2))] = '0;
    run_dump(to_tern(0), 3, 1, 5, 1'b0);

    // Address wraps from +9841 to -9841.
    mem[int'(to_tern(9841))]  = to_tern(123);
    mem[int'(to_tern(-9841))] = to_tern(-4567);
    run_dump({9{2'b01}}, 2, -1, 0, 1'b0);

    // Empty dump.
    run_dump(to_tern(5), 0, -1, 0, 1'b0);

    // Illegal trit code plus a start issued while busy.
    w = to_tern(-2000);
    w[7:6] = 2'b11;
    mem[int'(to_tern(300))] = w;
    run_dump(to_tern(300), 1, -1, 0, 1'b1);
    run_dump(to_tern(300), 0, -1, 0, 1'b0);

    // Reset in the middle of CONVERT aborts without a done pulse.
    mem[int'(to_tern(40))] = to_tern(999);
    start = 1'b1; start_addr = to_tern(40); word_count = 10'd2;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_read", {31'd0, mem_read}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_data", {16'd0, out_data}, 32'd0);
    check("abort_addr", {14'd0, out_addr}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    #3 reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy || out_valid) done_seen++;
    end
    check("abort_stays_idle", 32'(done_seen), 32'd0);

    // Randomized dumps.
    for (int t = 0; t < 8; t++) begin
      int base = int'($urandom_range(0, 19682)) - 9841;
      int cnt  = int'($urandom_range(1, 4));
      for (int k = 0; k < cnt; k++) begin
        w = to_tern(int'($urandom_range(0, 19682)) - 9841);
        if ($urandom_range(0, 3) == 0) begin
          int p = int'($urandom_range(0, 8));
          w[2*p +: 2] = 2'b11;
        end
        mem[int'(to_tern(wrap(base + k)))] = w;
      end
      run_dump(to_tern(base), cnt, int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
